// File: rtl/axi4lite_read_master.sv
// Single-outstanding AXI4-Lite read master: turns one read_en request into an AR/R
// transaction (or a local SLVERR for a misaligned address) and pulses read_done on completion.
module axi4lite_read_master #(
    parameter int         WIDTH_ADDR = 32,
    parameter int         WIDTH_DATA = 32,
    parameter logic [2:0] PROT       = 3'b000
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  read_en,
    input  logic [WIDTH_ADDR-1:0] read_addr_in,
    output logic [WIDTH_DATA-1:0] read_data_out,
    output logic [1:0]            read_response_out,
    output logic                  read_done,
    output logic                  busy,
    output logic [WIDTH_ADDR-1:0] m_araddr,
    output logic                  m_arvalid,
    input  logic                  m_arready,
    output logic [2:0]            m_arprot,
    input  logic [WIDTH_DATA-1:0] m_rdata,
    input  logic [1:0]            m_rresp,
    input  logic                  m_rvalid,
    output logic                  m_rready
);

    localparam int AL = $clog2(WIDTH_DATA / 8);

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        ADDR = 3'd1,
        DATA = 3'd2,
        ERR  = 3'd3,
        DONE = 3'd4
    } state_t;

    state_t                state_r, state_s;
    logic                  arvalid_r, arvalid_s;
    logic                  rready_r, rready_s;
    logic                  done_r, done_s;
    logic                  busy_r, busy_s;
    logic [WIDTH_ADDR-1:0] araddr_r, araddr_s;
    logic [WIDTH_DATA-1:0] rdata_r, rdata_s;
    logic [1:0]            rresp_r, rresp_s;
    logic                  misaligned_s;

    assign misaligned_s = (read_addr_in[AL-1:0] != {AL{1'b0}});

    // Next-state and next-output logic; every output is registered below.
    always_comb begin
        state_s   = state_r;
        arvalid_s = arvalid_r;
        rready_s  = rready_r;
        done_s    = 1'b0;
        busy_s    = busy_r;
        araddr_s  = araddr_r;
        rdata_s   = rdata_r;
        rresp_s   = rresp_r;
        case (state_r)
            IDLE: begin
                if (read_en) begin
                    busy_s = 1'b1;
                    if (misaligned_s) begin
                        state_s = ERR;
                    end else begin
                        state_s   = ADDR;
                        arvalid_s = 1'b1;
                        araddr_s  = read_addr_in;
                    end
                end else begin
                    state_s = IDLE;
                end
            end
            ADDR: begin
                if (m_arready) begin
                    arvalid_s = 1'b0;
                    rready_s  = 1'b1;
                    state_s   = DATA;
                end else begin
                    state_s = ADDR;
                end
            end
            DATA: begin
                if (m_rvalid) begin
                    rdata_s  = m_rdata;
                    rresp_s  = m_rresp;
                    rready_s = 1'b0;
                    done_s   = 1'b1;
                    state_s  = DONE;
                end else begin
                    state_s = DATA;
                end
            end
            ERR: begin
                // Local SLVERR: no AXI traffic, zero data.
                rdata_s = {WIDTH_DATA{1'b0}};
                rresp_s = 2'b10;
                done_s  = 1'b1;
                state_s = DONE;
            end
            DONE: begin
                busy_s  = 1'b0;
                state_s = IDLE;
            end
            default: begin
                state_s   = IDLE;
                arvalid_s = 1'b0;
                rready_s  = 1'b0;
                busy_s    = 1'b0;
            end
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r   <= IDLE;
            arvalid_r <= 1'b0;
            rready_r  <= 1'b0;
            done_r    <= 1'b0;
            busy_r    <= 1'b0;
            araddr_r  <= {WIDTH_ADDR{1'b0}};
            rdata_r   <= {WIDTH_DATA{1'b0}};
            rresp_r   <= 2'b00;
        end else begin
            state_r   <= state_s;
            arvalid_r <= arvalid_s;
            rready_r  <= rready_s;
            done_r    <= done_s;
            busy_r    <= busy_s;
            araddr_r  <= araddr_s;
            rdata_r   <= rdata_s;
            rresp_r   <= rresp_s;
        end
    end

    assign m_arvalid         = arvalid_r;
    assign m_rready          = rready_r;
    assign m_araddr          = araddr_r;
    assign m_arprot          = PROT;
    assign read_done         = done_r;
    assign busy              = busy_r;
    assign read_data_out     = rdata_r;
    assign read_response_out = rresp_r;

endmodule

// File: tb/tb_axi4lite_read_master.sv
// Directed bench for axi4lite_read_master: a table of single transactions against a
// configurable-latency slave model, plus hand-written reset, back-to-back and abort sequences.
module tb_axi4lite_read_master;

    localparam logic [2:0] PROT_TB = 3'b101;

    logic        clk;
    logic        reset;
    logic        read_en;
    logic [31:0] read_addr_in;
    logic [31:0] read_data_out;
    logic [1:0]  read_response_out;
    logic        read_done;
    logic        busy;
    logic [31:0] m_araddr;
    logic        m_arvalid;
    logic        m_arready;
    logic [2:0]  m_arprot;
    logic [31:0] m_rdata;
    logic [1:0]  m_rresp;
    logic        m_rvalid;
    logic        m_rready;

    axi4lite_read_master #(
        .WIDTH_ADDR(32),
        .WIDTH_DATA(32),
        .PROT      (PROT_TB)
    ) dut (
        .clk              (clk),
        .reset            (reset),
        .read_en          (read_en),
        .read_addr_in     (read_addr_in),
        .read_data_out    (read_data_out),
        .read_response_out(read_response_out),
        .read_done        (read_done),
        .busy             (busy),
        .m_araddr         (m_araddr),
        .m_arvalid        (m_arvalid),
        .m_arready        (m_arready),
        .m_arprot         (m_arprot),
        .m_rdata          (m_rdata),
        .m_rresp          (m_rresp),
        .m_rvalid         (m_rvalid),
        .m_rready         (m_rready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        int          ard;       // cycles arready lags arvalid
        int          rd;        // cycles rvalid lags rready
        logic [31:0] rdata;
        logic [1:0]  rresp;
        bit          early;     // rvalid driven high from the start of the request
        logic [31:0] exp_data;
        logic [1:0]  exp_resp;
        int          exp_edge;  // edge index (read_en edge = 0) after which read_done is high
        int          exp_hs;    // expected AR and R handshakes
    } vec_t;

    vec_t vecs[8];

    int n_checks = 0;
    int n_fails  = 0;
    int ar_hs = 0, r_hs = 0, done_cnt = 0, overlap = 0;

    int          cfg_ard, cfg_rd, arw, rw;
    logic [31:0] cfg_rdata;
    logic [1:0]  cfg_rresp;
    bit          cfg_early;

    // Bus event counters sampled on the active edge.
    always @(posedge clk) begin
        if (m_arvalid && m_arready) ar_hs <= ar_hs + 1;
        if (m_rvalid && m_rready)   r_hs <= r_hs + 1;
        if (read_done)              done_cnt <= done_cnt + 1;
        if (m_arvalid && m_rready)  overlap <= overlap + 1;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic slave_step();
        m_rdata = cfg_rdata;
        m_rresp = cfg_rresp;
        if (m_arvalid) begin
            arw++;
            m_arready = (arw > cfg_ard);
        end else begin
            arw = 0;
            m_arready = 1'b0;
        end
        if (cfg_early) begin
            m_rvalid = 1'b1;
        end else if (m_rready) begin
            rw++;
            m_rvalid = (rw > cfg_rd);
        end else begin
            rw = 0;
            m_rvalid = 1'b0;
        end
    endtask

    task automatic run_txn(input int i);
        int k, done_edge, ar0, r0, d0, ov0, addr_bad;
        vec_t v;
        v = vecs[i];
        cfg_ard = v.ard; cfg_rd = v.rd; cfg_rdata = v.rdata;
        cfg_rresp = v.rresp; cfg_early = v.early;
        arw = 0; rw = 0; addr_bad = 0; done_edge = -1;
        @(negedge clk);
        ar0 = ar_hs; r0 = r_hs; d0 = done_cnt; ov0 = overlap;
        read_en = 1'b1;
        read_addr_in = v.addr;
        @(posedge clk);
        @(negedge clk);
        read_en = 1'b0;
        k = 0;
        while (k < 40) begin
            if (read_done && done_edge < 0) begin
                done_edge = k;
                check($sformatf("v%0d busy_at_done", i), 64'(busy), 64'd1);
            end
            if (m_arvalid && m_araddr !== v.addr) addr_bad++;
            slave_step();
            if (done_edge >= 0 && k > done_edge) break;
            @(negedge clk);
            k++;
        end
        if (done_edge < 0) begin
            n_checks++;
            n_fails++;
            $display("FAIL v%0d done_timeout: got none expected edge %0d", i, v.exp_edge);
        end
        check($sformatf("v%0d done_edge", i), 64'(done_edge), 64'(v.exp_edge));
        check($sformatf("v%0d data", i), 64'(read_data_out), 64'(v.exp_data));
        check($sformatf("v%0d resp", i), 64'(read_response_out), 64'(v.exp_resp));
        check($sformatf("v%0d ar_hs", i), 64'(ar_hs - ar0), 64'(v.exp_hs));
        check($sformatf("v%0d r_hs", i), 64'(r_hs - r0), 64'(v.exp_hs));
        check($sformatf("v%0d done_pulses", i), 64'(done_cnt - d0), 64'd1);
        check($sformatf("v%0d araddr_stable", i), 64'(addr_bad), 64'd0);
        check($sformatf("v%0d ar_r_overlap", i), 64'(overlap - ov0), 64'd0);
        check($sformatf("v%0d busy_after", i), 64'(busy), 64'd0);
        m_rvalid = 1'b0;
        m_arready = 1'b0;
        cfg_early = 1'b0;
        @(negedge clk);
        check($sformatf("v%0d data_hold", i), 64'(read_data_out), 64'(v.exp_data));
    endtask

    initial begin
        int d0, a0;
        vecs[0] = '{32'h0000_0010, 0, 0, 32'hDEAD_BEEF, 2'b00, 1'b0, 32'hDEAD_BEEF, 2'b00, 2, 1};
        vecs[1] = '{32'h0000_0020, 4, 0, 32'h1234_5678, 2'b00, 1'b0, 32'h1234_5678, 2'b00, 6, 1};
        vecs[2] = '{32'h0000_0013, 0, 0, 32'hFFFF_FFFF, 2'b00, 1'b0, 32'h0000_0000, 2'b10, 1, 0};
        vecs[3] = '{32'h0000_0024, 0, 0, 32'h0000_0000, 2'b11, 1'b0, 32'h0000_0000, 2'b11, 2, 1};
        vecs[4] = '{32'h0000_0030, 1, 3, 32'hA5A5_5A5A, 2'b01, 1'b0, 32'hA5A5_5A5A, 2'b01, 6, 1};
        vecs[5] = '{32'h0000_0040, 2, 0, 32'hCAFE_F00D, 2'b00, 1'b1, 32'hCAFE_F00D, 2'b00, 4, 1};
        vecs[6] = '{32'hFFFF_FFFC, 0, 0, 32'h0000_0001, 2'b00, 1'b0, 32'h0000_0001, 2'b00, 2, 1};
        vecs[7] = '{32'h0000_0002, 0, 0, 32'h7777_7777, 2'b01, 1'b0, 32'h0000_0000, 2'b10, 1, 0};

        reset = 1'b1; read_en = 1'b0; read_addr_in = 32'h0;
        m_arready = 1'b0; m_rdata = 32'h0; m_rresp = 2'b00; m_rvalid = 1'b0;
        cfg_ard = 0; cfg_rd = 0; cfg_rdata = 32'h0; cfg_rresp = 2'b00; cfg_early = 1'b0;
        arw = 0; rw = 0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_arprot", 64'(m_arprot), 64'(PROT_TB));
        check("rst_arvalid", 64'(m_arvalid), 64'd0);
        check("rst_rready", 64'(m_rready), 64'd0);
        check("rst_done", 64'(read_done), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_araddr", 64'(m_araddr), 64'd0);
        check("rst_data", 64'(read_data_out), 64'd0);
        check("rst_resp", 64'(read_response_out), 64'd0);
        reset = 1'b0;

        for (int i = 0; i < 8; i++) run_txn(i);

        // read_en held high: one request per four cycles, nothing queued while busy.
        cfg_ard = 0; cfg_rd = 0; cfg_rdata = 32'h1111_2222; cfg_rresp = 2'b00; cfg_early = 1'b0;
        arw = 0; rw = 0;
        @(negedge clk);
        d0 = done_cnt; a0 = ar_hs;
        read_en = 1'b1;
        read_addr_in = 32'h0000_0060;
        for (int c = 0; c < 12; c++) begin
            @(posedge clk);
            @(negedge clk);
            slave_step();
        end
        read_en = 1'b0;
        @(posedge clk);
        @(negedge clk);
        slave_step();
        check("b2b ar_hs", 64'(ar_hs - a0), 64'd3);
        check("b2b done_pulses", 64'(done_cnt - d0), 64'd3);
        check("b2b busy_after", 64'(busy), 64'd0);
        check("b2b data", 64'(read_data_out), 64'h1111_2222);
        check("arprot_run", 64'(m_arprot), 64'(PROT_TB));

        // Reset while waiting for read data abandons the transaction.
        cfg_ard = 0; cfg_rd = 1000; cfg_rdata = 32'h9999_9999;
        arw = 0; rw = 0;
        @(negedge clk);
        d0 = done_cnt;
        read_en = 1'b1;
        read_addr_in = 32'h0000_0050;
        @(posedge clk);
        @(negedge clk);
        read_en = 1'b0;
        begin
            int k;
            k = 0;
            while (k < 10 && !m_rready) begin
                slave_step();
                @(negedge clk);
                k++;
            end
        end
        check("abort reached_data", 64'(m_rready), 64'd1);
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        m_rvalid = 1'b0;
        m_arready = 1'b0;
        check("abort rready", 64'(m_rready), 64'd0);
        check("abort busy", 64'(busy), 64'd0);
        check("abort arvalid", 64'(m_arvalid), 64'd0);
        check("abort done", 64'(read_done), 64'd0);
        reset = 1'b0;
        @(negedge clk);
        check("abort no_done", 64'(done_cnt - d0), 64'd0);
        run_txn(0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
